// File: rtl/intr_ctrl.sv
// Interrupt controller: two synchronised edge-triggered external lines plus a
// periodic timer, latched as pending bits, masked, prioritised, single in-service level.

module intr_sync (
  input  logic clk,
  input  logic reset,
  input  logic irq,
  output logic rise
);
  logic s1, s2, h;

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      h  <= 1'b0;
    end else begin
      s1 <= irq;
      s2 <= s1;
      h  <= s2;
    end
  end

  assign rise = s2 & ~h;
endmodule

module intr_ctrl #(
  parameter int TIMER_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ext_irq1,
  input  logic               ext_irq2,
  input  logic               timer_we,
  input  logic [TIMER_W-1:0] timer_period,
  input  logic               mask_we,
  input  logic [2:0]         mask_in,
  input  logic               ack,
  input  logic               reti,
  output logic               intr1,
  output logic               intr2,
  output logic [2:0]         pending,
  output logic               in_service
);
  localparam int NUM_EXT = 2;

  logic [NUM_EXT-1:0] ext_irq, ext_rise;
  assign ext_irq = {ext_irq2, ext_irq1};

  for (genvar g = 0; g < NUM_EXT; g++) begin : g_sync
    intr_sync u_sync (
      .clk   (clk),
      .reset (reset),
      .irq   (ext_irq[g]),
      .rise  (ext_rise[g])
    );
  end

  // Timer: a write restarts the count, so it suppresses a tick on that edge.
  logic [TIMER_W-1:0] period, cnt;
  logic               tick;

  assign tick = (period != '0) && (cnt == '0) && !timer_we;

  always_ff @(posedge clk) begin
    if (!reset) begin
      period <= '0;
      cnt    <= '0;
    end else if (timer_we) begin
      period <= timer_period;
      cnt    <= timer_period - TIMER_W'(1);
    end else if (period != '0) begin
      cnt    <= tick ? period - TIMER_W'(1) : cnt - TIMER_W'(1);
    end
  end

  // isrc: 0 = idle, 1 = ext1, 2 = ext2, 3 = timer; in_service is its non-idle flag.
  logic [2:0] pend, mask, evt, elig, elig_post, grant;
  logic [1:0] isrc, isrc_nxt;
  logic       is_post;

  assign evt        = {tick, ext_rise};
  assign in_service = |isrc;
  assign is_post    = in_service & ~reti;
  assign elig_post  = pend & mask & {3{~is_post}};

  always_comb begin
    grant    = 3'b000;
    isrc_nxt = is_post ? isrc : 2'd0;
    if (ack) begin
      if (elig_post[0]) begin
        grant    = 3'b001;
        isrc_nxt = 2'd1;
      end else if (elig_post[1]) begin
        grant    = 3'b010;
        isrc_nxt = 2'd2;
      end else if (elig_post[2]) begin
        grant    = 3'b100;
        isrc_nxt = 2'd3;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pend <= 3'b000;
      mask <= 3'b000;
      isrc <= 2'd0;
    end else begin
      pend <= (pend & ~grant) | evt;
      if (mask_we) mask <= mask_in;
      isrc <= isrc_nxt;
    end
  end

  assign elig    = pend & mask & {3{~in_service}};
  assign intr1   = elig[0];
  assign intr2   = ~elig[0] & (elig[1] | elig[2]);
  assign pending = pend;
endmodule

// File: doc/intr_ctrl.md
# intr_ctrl

Interrupt controller for the single-cycle CPU; sits directly upstream of the control unit and drives its `intr1`/`intr2` request inputs. It synchronises and edge-detects two external interrupt lines and runs a programmable periodic timer. It latches events as pending bits, applies a mask, and presents one prioritised request at a time. It also tracks a single in-service level through an ack/return handshake with the control unit.

## Interface
- `TIMER_W`, 16: width of timer period and counter.
- `clk` input 1: system clock, all state updates on rising edge.
- `reset` input 1: synchronous reset, active-low (`reset == 0` at a rising edge resets all state).
- `ext_irq1` input 1: asynchronous external interrupt line 1, rising-edge triggered.
- `ext_irq2` input 1: asynchronous external interrupt line 2, rising-edge triggered.
- `timer_we` input 1: load `timer_period` into the period register (timer opcode).
- `timer_period` input TIMER_W: new timer period in clock cycles; 0 disables the timer.
- `mask_we` input 1: load `mask_in` into the mask register.
- `mask_in` input 3: enable bits {timer, ext2, ext1}; 1 = enabled.
- `ack` input 1: control unit accepts the currently presented request (one-cycle pulse).
- `reti` input 1: return from interrupt (one-cycle pulse).
- `intr1` output 1: request to control unit, source ext1.
- `intr2` output 1: request to control unit, source ext2 or timer.
- `pending` output 3: raw pending bits {timer, ext2, ext1}, unmasked.
- `in_service` output 1: an interrupt has been acked and not yet returned.

## Operation
- Sync: each `ext_irqN` passes through two flops (`s1`, `s2`) plus a history flop `h`. An edge is registered when `s2 & ~h`.
- Pending: a bit is set on its event and cleared on `ack` of that source. Set has priority over clear in the same cycle, so no event is lost. Repeated events while a bit is already pending collapse into one.
- Timer: `cnt` (TIMER_W) is reloaded to `timer_period-1` on `timer_we`.
  - While the period is non-zero, `cnt` decrements each cycle. On the cycle it reads 0, the block sets `pend[2]` and reloads `cnt` to period-1. An interrupt therefore fires every `timer_period` cycles; period 1 fires every cycle.
  - Period 0: `cnt` holds and no timer events occur.
  - `timer_we` during a running count restarts the count immediately. It does not clear `pend[2]`.
- Eligibility: `elig = pend & mask & {3{~in_service}}`.
- Priority: ext1 > ext2 > timer.
  - `intr1 = elig[0]`.
  - `intr2 = ~elig[0] & (elig[1] | elig[2])`.
  - At most one output is high.
- Ack: on `ack`, the block clears the highest-priority eligible pending bit, sets `in_service`, and records the acked source in `isrc` (2 bits, internal). `ack` when no request is presented is ignored and changes no state.
- Return: `reti` clears `in_service`. `reti` without `in_service` is ignored. `ack` and `reti` in the same cycle: `reti` takes effect first, then `ack` is evaluated against the post-`reti` state, leaving `in_service` = 1.
- No nesting: a single in-service level; all requests are blocked while `in_service` = 1, but events still latch into pending.
- Mask: masking does not clear pending. Unmasking a pending bit raises the request on the next cycle.
- Reset values:
  - `pend` = 0, `mask` = 3'b000 (all disabled), period = 0, `cnt` = 0, `in_service` = 0.
  - Sync/history flops = 0.
  - Outputs `intr1` = `intr2` = 0, `pending` = 0, `in_service` = 0.
  - Reset mid-service or with pending bits discards everything.

## Timing
- Outputs are combinational from registers only; there are no combinational paths from inputs to outputs.
- External latency: `ext_irqN` first sampled high at edge k → `s1` at k, `s2` at k+1, `pend` set at k+2 (`h` also updates at k+2). `intr` is visible after edge k+2, provided it is masked in and not in service.
- A pulse must be high for at least one sampling edge to be caught. A line held high produces exactly one event.
- Timer: `timer_we` at edge k with period P → first `pend[2]` set at edge k+P, then every P cycles.
- Ack at edge k: the request drops after k, the next request is visible after k only if not blocked. In practice it is blocked until `reti`.
- `mask_we` and `timer_we` take effect at the writing edge.

## Test plan
- Reset/basic:
  - Hold `reset` = 0 for 2 cycles → all outputs 0.
  - Set `mask` = 3'b111, pulse `ext_irq1` for 1 cycle → `intr1` = 1 exactly 3 edges later.
  - `ack` → `intr1` = 0, `in_service` = 1.
  - `reti` → `in_service` = 0.
- Priority:
  - Raise `ext_irq2` and `ext_irq1` on the same edge → `intr1` only.
  - `ack`, `reti` → `intr2` = 1, `pending` = 3'b010.
- Timer:
  - Write period 5 → `pend[2]` set 5, 10, 15 cycles after the write; without ack, `pending[2]` stays 1 and only one request is presented.
  - Write period 0 → no further events.
- Mask/block:
  - `mask` = 3'b000, `ext_irq2` edge → `pending` = 3'b010, `intr2` = 0.
  - Then `mask` = 3'b010 → `intr2` = 1 on the next cycle.
  - While `in_service`, an `ext_irq1` edge latches in pending; `intr1` appears only after `reti`.
- Collisions:
  - `ext_irq1` edge reaching `pend` on the same edge as `ack` of ext1 → `pend[0]` stays 1.
  - `ack` + `reti` in the same cycle with a request presented → `in_service` stays 1.
  - `ack` with no request → no state change.
- Reset mid-operation: with `in_service` = 1, `pending` = 3'b111 and the timer running, assert `reset` = 0 for one edge → all state is zero and no timer events follow until a new period is written.
